// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 streaming filter.
//   mode_e     - kernel select encodings
//   acc_width  - signed accumulator width for a given sample width
//   saturate   - clamp a signed kernel result into the unsigned pixel range
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_SOBEL_X = 2'd0,
        MODE_SOBEL_Y = 2'd1,
        MODE_BLUR    = 2'd2,
        MODE_PASS    = 2'd3
    } mode_e;

    // Blur sum peaks at 16*(2^data_w-1); five extra bits keep it positive
    // in a signed accumulator.
    function automatic int acc_width(input int data_w);
        return data_w + 5;
    endfunction

    function automatic int saturate(input int v, input int data_w);
        int max_v;
        max_v = (1 << data_w) - 1;
        if (v < 0) return 0;
        if (v > max_v) return max_v;
        return v;
    endfunction

endpackage

// File: rtl/conv3x3_channel_core.sv
// conv3x3_channel_core: one colour channel of the 3x3 filter.
//   clk, rst  - clock, synchronous active-high reset (window only)
//   accept    - a pixel beat is accepted this cycle
//   col       - column of the accepted beat (line-buffer address)
//   mode      - active kernel
//   pix       - incoming sample for this channel
//   result    - saturated kernel output for the window that includes pix
module conv3x3_channel_core
    import conv_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 16,
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [COL_W-1:0]  col,
    input  mode_e             mode,
    input  logic [DATA_W-1:0] pix,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W = acc_width(DATA_W);

    logic [DATA_W-1:0] linebuf0 [IMG_W];   // previous line
    logic [DATA_W-1:0] linebuf1 [IMG_W];   // line before that
    logic [DATA_W-1:0] w  [3][3];          // [row][col], row 0 = top, col 0 = left
    logic [DATA_W-1:0] wn [3][3];          // window as it will be after this beat
    logic signed [ACC_W-1:0] s [3][3];
    logic signed [ACC_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1[col] <= linebuf0[col];
            linebuf0[col] <= pix;
        end
    end

    // Shift left, new column enters on the right from the line buffers.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            wn[r][0] = w[r][1];
            wn[r][1] = w[r][2];
        end
        wn[0][2] = linebuf1[col];
        wn[1][2] = linebuf0[col];
        wn[2][2] = pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r][c] <= '0;
        end else if (accept) begin
            w <= wn;
        end
    end

    // Kernel runs on the post-shift window so the result is ready in the
    // same cycle as the completing beat.
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s[r][c] = signed'({{(ACC_W-DATA_W){1'b0}}, wn[r][c]});
        acc = '0;
        case (mode)
            MODE_SOBEL_X: acc = (s[0][0] + (s[1][0] <<< 1) + s[2][0])
                              - (s[0][2] + (s[1][2] <<< 1) + s[2][2]);
            MODE_SOBEL_Y: acc = (s[0][0] + (s[0][1] <<< 1) + s[0][2])
                              - (s[2][0] + (s[2][1] <<< 1) + s[2][2]);
            MODE_BLUR:    acc = (s[0][0] + (s[0][1] <<< 1) + s[0][2]
                              + (s[1][0] <<< 1) + (s[1][1] <<< 2) + (s[1][2] <<< 1)
                              + s[2][0] + (s[2][1] <<< 1) + s[2][2]) >>> 4;
            MODE_PASS:    acc = s[1][1];
            default:      acc = '0;
        endcase
        result = DATA_W'(saturate(int'(acc), DATA_W));
    end

endmodule

// File: rtl/conv3x3_stream_filter.sv
// conv3x3_stream_filter: streaming multichannel 3x3 image filter.
//   clk, rst   - clock, synchronous active-high reset
//   mode       - kernel select, latched on an accepted sof beat
//   in_valid / in_ready / in_sof / in_data   - raster pixel input
//   out_valid / out_ready / out_data         - filtered pixel output
// Border pixels produce no output: an H-line frame yields (H-2)*(IMG_W-2).
module conv3x3_stream_filter
    import conv_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int CHANNELS = 3,
    parameter int IMG_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic [DATA_W*CHANNELS-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W*CHANNELS-1:0] out_data
);

    localparam int COL_W = $clog2(IMG_W);

    logic [COL_W-1:0] col, beat_col;
    logic [1:0]       row, beat_row;
    mode_e            mode_q;
    logic             accept, win_valid;
    logic [CHANNELS-1:0][DATA_W-1:0] res;

    // Single output register: a new beat is taken whenever the register is
    // empty or is being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // sof restarts the frame on this very beat.
    assign beat_col  = in_sof ? '0 : col;
    assign beat_row  = in_sof ? 2'd0 : row;
    assign win_valid = accept && (beat_row == 2'd2) && (beat_col >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= '0;
            row    <= 2'd0;
            mode_q <= MODE_SOBEL_X;
        end else if (accept) begin
            if (in_sof)
                mode_q <= mode_e'(mode);
            if (beat_col == COL_W'(IMG_W-1)) begin
                col <= '0;
                row <= (beat_row == 2'd2) ? 2'd2 : beat_row + 2'd1;
            end else begin
                col <= beat_col + COL_W'(1);
                row <= beat_row;
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        conv3x3_channel_core #(
            .DATA_W (DATA_W),
            .IMG_W  (IMG_W),
            .COL_W  (COL_W)
        ) u_core (
            .clk    (clk),
            .rst    (rst),
            .accept (accept),
            .col    (beat_col),
            .mode   (mode_q),
            .pix    (in_data[ch*DATA_W +: DATA_W]),
            .result (res[ch])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (win_valid) begin
            out_valid <= 1'b1;
            out_data  <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_filter.sv
module tb_conv3x3_stream_filter;
    localparam int DW = 4, CH = 3, W = 8, MAXH = 8;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_sof, out_valid, out_ready;
    logic [1:0] mode;
    logic [DW*CH-1:0] in_data, out_data;

    conv3x3_stream_filter #(.DATA_W(DW), .CHANNELS(CH), .IMG_W(W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [DW-1:0] img [CH][MAXH][W];
    logic [DW*CH-1:0] exp_q[$], got_q[$], stall_q[$];
    logic stall_rdy_q[$];
    int first_out, acc22;

    // Reference: direct 3x3 neighbourhood of the stored image.
    task automatic build_expected(input int h, input int m);
        exp_q.delete();
        for (int r = 2; r < h; r++)
            for (int c = 2; c < W; c++) begin
                logic [DW*CH-1:0] v;
                v = '0;
                for (int ch = 0; ch < CH; ch++) begin
                    int p [3][3];
                    int k;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            p[i][j] = int'(img[ch][r-2+i][c-2+j]);
                    case (m)
                        0: k = (p[0][0] + 2*p[1][0] + p[2][0]) - (p[0][2] + 2*p[1][2] + p[2][2]);
                        1: k = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
                        2: k = (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1]
                              + 2*p[1][2] + p[2][0] + 2*p[2][1] + p[2][2]) / 16;
                        default: k = p[1][1];
                    endcase
                    if (k < 0) k = 0;
                    if (k > 15) k = 15;
                    v[ch*DW +: DW] = k[DW-1:0];
                end
                exp_q.push_back(v);
            end
    endtask

    task automatic sample_outputs(input int cyc);
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (out_valid && first_out < 0) first_out = cyc;
        if (out_valid && !out_ready) begin
            stall_q.push_back(out_data);
            stall_rdy_q.push_back(in_ready);
        end
    endtask

    // Drives one frame (sof on the first beat) and captures every output transfer.
    task automatic stream_frame(input int h, input logic [1:0] m_sof, input logic [1:0] m_after,
                                input int stall_at, input int stall_len, input int gap_every);
        int idx, cyc, n;
        idx = 0; cyc = 0; n = h * W;
        got_q.delete(); stall_q.delete(); stall_rdy_q.delete();
        first_out = -1; acc22 = -1;
        while (idx < n && cyc < 2000) begin
            int r, c;
            r = idx / W; c = idx % W;
            in_valid  = (gap_every == 0) || (cyc % gap_every != gap_every - 1);
            in_sof    = (idx == 0);
            mode      = (idx == 0) ? m_sof : m_after;
            in_data   = {img[2][r][c], img[1][r][c], img[0][r][c]};
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            sample_outputs(cyc);
            if (in_valid && in_ready) begin
                if (idx == 2*W + 2) acc22 = cyc + 1;
                idx++;
            end
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (idx < n) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d beats, required %0d", idx, n);
        end
        in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk); sample_outputs(cyc);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1; mode = 2'd0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b, expected 0", out_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sobel_flat;
        for (int ch = 0; ch < CH; ch++) for (int r = 0; r < MAXH; r++) for (int c = 0; c < W; c++) img[ch][r][c] = 4'd5;
        build_expected(4, 0);
        stream_frame(4, 2'd0, 2'd0, 0, 0, 0);
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL flat_count: got %0d outputs, expected 12", got_q.size()); end
        checks++; if (acc22 < 0 || first_out != acc22) begin errors++; $display("FAIL flat_latency: first output cycle %0d, expected %0d", first_out, acc22); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW*CH-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL flat_data: got %h, expected %h", g, e); end
        end
    endtask

    task automatic test_sobel_edge;
        for (int r = 0; r < MAXH; r++)
            for (int c = 0; c < W; c++) begin
                img[0][r][c] = (c < 4) ? 4'd15 : 4'd0;
                img[1][r][c] = (c < 4) ? 4'd0 : 4'd15;
                img[2][r][c] = 4'd7;
            end
        build_expected(4, 0);
        stream_frame(4, 2'd0, 2'd0, 0, 0, 0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL edge_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW*CH-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL edge_data: got %h, expected %h", g, e); end
        end
    endtask

    task automatic test_blur_pass;
        for (int ch = 0; ch < CH; ch++) for (int r = 0; r < MAXH; r++) for (int c = 0; c < W; c++) img[ch][r][c] = 4'd9;
        build_expected(4, 2);
        stream_frame(4, 2'd2, 2'd2, 0, 0, 0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL blur_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW*CH-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL blur_data: got %h, expected %h", g, e); end
        end
        for (int ch = 0; ch < CH; ch++) for (int r = 0; r < MAXH; r++) for (int c = 0; c < W; c++) img[ch][r][c] = 4'(c);
        build_expected(4, 3);
        stream_frame(4, 2'd3, 2'd3, 0, 0, 0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL pass_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW*CH-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL pass_data: got %h, expected %h", g, e); end
        end
    endtask

    task automatic test_backpressure;
        for (int ch = 0; ch < CH; ch++) for (int r = 0; r < MAXH; r++) for (int c = 0; c < W; c++) img[ch][r][c] = 4'($urandom_range(0, 15));
        build_expected(4, 2);
        stream_frame(4, 2'd2, 2'd2, 20, 5, 0);
        checks++; if (stall_q.size() != 5) begin errors++; $display("FAIL bp_stall_len: got %0d held cycles, expected 5", stall_q.size()); end
        for (int i = 1; i < stall_q.size(); i++) begin
            checks++; if (stall_q[i] !== stall_q[0]) begin errors++; $display("FAIL bp_stable: got %h, expected %h", stall_q[i], stall_q[0]); end
        end
        for (int i = 0; i < stall_rdy_q.size(); i++) begin
            checks++; if (stall_rdy_q[i] !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", stall_rdy_q[i]); end
        end
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL bp_count: got %0d outputs, expected 12", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW*CH-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL bp_data: got %h, expected %h", g, e); end
        end
    endtask

    task automatic test_mode_change;
        for (int ch = 0; ch < CH; ch++) for (int r = 0; r < MAXH; r++) for (int c = 0; c < W; c++) img[ch][r][c] = 4'($urandom_range(0, 15));
        for (int f = 0; f < 2; f++) begin
            build_expected(4, (f == 0) ? 2 : 1);
            if (f == 0) stream_frame(4, 2'd2, 2'd0, 0, 0, 0);
            else        stream_frame(4, 2'd1, 2'd3, 0, 0, 0);
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL modechg_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                logic [DW*CH-1:0] g, e;
                g = got_q.pop_front(); e = exp_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL modechg_data: frame %0d got %h, expected %h", f, g, e); end
            end
        end
    endtask

    task automatic test_reset_midframe;
        for (int ch = 0; ch < CH; ch++) for (int r = 0; r < MAXH; r++) for (int c = 0; c < W; c++) img[ch][r][c] = 4'($urandom_range(0, 15));
        out_ready = 1'b1; mode = 2'd0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_sof = (i == 0);
            in_data = {img[2][i/W][i%W], img[1][i/W][i%W], img[0][i/W][i%W]};
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %b, expected 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, expected 1", in_ready); end
        checks++; if (dut.col !== '0) begin errors++; $display("FAIL rstmid_col: got %0d, expected 0", dut.col); end
        checks++; if (dut.row !== '0) begin errors++; $display("FAIL rstmid_row: got %0d, expected 0", dut.row); end
        build_expected(4, 3);
        stream_frame(4, 2'd3, 2'd3, 0, 0, 0);
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL rstmid_count: got %0d outputs, expected 12", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [DW*CH-1:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL rstmid_data: got %h, expected %h", g, e); end
        end
    endtask

    task automatic test_random;
        for (int m = 0; m < 4; m++) begin
            for (int ch = 0; ch < CH; ch++) for (int r = 0; r < MAXH; r++) for (int c = 0; c < W; c++) img[ch][r][c] = 4'($urandom_range(0, 15));
            build_expected(5, m);
            stream_frame(5, 2'(m), 2'(3 - m), 25 + m, 3, 3);
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: mode %0d got %0d outputs, expected %0d", m, got_q.size(), exp_q.size()); end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                logic [DW*CH-1:0] g, e;
                g = got_q.pop_front(); e = exp_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL rand_data: mode %0d got %h, expected %h", m, g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sobel_flat();
        test_sobel_edge();
        test_blur_pass();
        test_backpressure();
        test_mode_change();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
